frame_buffer_ram: RTL

//  Double-buffered, parametrised colour-index framebuffer between the rasteriser (write side) and the
//  VGA scan-out (read side). Scan-out always reads the front bank; the renderer writes the back bank.

---
 rtl/fb_pkg.sv | 25 ++
 rtl/fb_bank.sv | 29 ++
 rtl/frame_buffer_ram.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the double-buffered framebuffer: default geometry,
// width derivation helpers and the clear-engine state encoding.
package fb_pkg;

    localparam int NUMBER_COLORS_DEF = 10;
    localparam int FB_WIDTH_DEF      = 320;
    localparam int FB_HEIGHT_DEF     = 240;

    // Clear engine states: idle, or filling the back bank one pixel per clock.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Bits per pixel for a palette of n colours.
    function automatic int color_w(input int n);
        return $clog2(n) + 1;
    endfunction

    // Address bits for a w x h frame.
    function automatic int addr_w(input int w, input int h);
        return $clog2(w * h);
    endfunction

endpackage

// File: rtl/fb_bank.sv
// One framebuffer bank: simple dual-port RAM with one write port and one
// registered read port. Contents are deliberately not reset (block RAM).
module fb_bank #(
    parameter int DEPTH = 76800,
    parameter int AW    = 17,
    parameter int DW    = 5
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Synchronous write and registered read of the pixel store.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_ram.sv
// Double-buffered colour-index framebuffer. Scan-out reads the front bank,
// the renderer and the clear engine write the back bank, and the banks only
// exchange on a vblank rising edge while no clear is running.
module frame_buffer_ram
    import fb_pkg::*;
#(
    parameter int  NUMBER_COLORS = NUMBER_COLORS_DEF,
    parameter int  FB_WIDTH      = FB_WIDTH_DEF,
    parameter int  FB_HEIGHT     = FB_HEIGHT_DEF,
    localparam int COLOR_W       = color_w(NUMBER_COLORS),
    localparam int PIX           = FB_WIDTH * FB_HEIGHT,
    localparam int ADDR_W        = addr_w(FB_WIDTH, FB_HEIGHT),
    localparam int XW            = $clog2(FB_WIDTH),
    localparam int YW            = $clog2(FB_HEIGHT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [XW-1:0]      rx,
    input  logic [YW-1:0]      ry,
    output logic [COLOR_W-1:0] rdata,
    input  logic [XW-1:0]      wx,
    input  logic [YW-1:0]      wy,
    input  logic [COLOR_W-1:0] wdata,
    input  logic               we,
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               clear_busy,
    input  logic               swap_req,
    input  logic               vblank,
    output logic               swap_pending,
    output logic               swap_ack,
    output logic               front_sel
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX - 1);

    // Column-major pixel address: y + FB_HEIGHT * x.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [XW-1:0] x,
                                                   input logic [YW-1:0] y);
        logic [ADDR_W-1:0] xa;
        logic [ADDR_W-1:0] ya;
        logic [ADDR_W-1:0] ha;
        xa = ADDR_W'(x);
        ya = ADDR_W'(y);
        ha = ADDR_W'(FB_HEIGHT);
        return ya + ha * xa;
    endfunction

    // Coordinate range check, widened so power-of-two sizes still compare correctly.
    function automatic logic in_range(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return ({1'b0, x} < (XW + 1)'(FB_WIDTH)) && ({1'b0, y} < (YW + 1)'(FB_HEIGHT));
    endfunction

    clr_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [COLOR_W-1:0] clear_color_q, clear_color_d;
    logic               front_sel_q, front_sel_d;
    logic               swap_pending_q, swap_pending_d;
    logic               swap_ack_q, swap_ack_d;
    logic               vblank_q;
    logic               rd_valid_q;
    logic               rd_sel_q;

    logic               vblank_rise_s;
    logic               swap_now_s;
    logic               rd_ok_s;
    logic [ADDR_W-1:0]  raddr_s;
    logic               wr_en_s;
    logic [ADDR_W-1:0]  waddr_s;
    logic [COLOR_W-1:0] wdata_s;
    logic [1:0]         bank_we_s;
    logic [COLOR_W-1:0] bank_rdata_s [2];

    assign vblank_rise_s = vblank & ~vblank_q;

    // A swap happens on a vblank rising edge when one is requested (now or earlier) and no fill runs.
    assign swap_now_s = vblank_rise_s & (swap_pending_q | swap_req) & (state_q == ST_IDLE);

    // Next-state logic for the clear engine and the swap handshake.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        clear_color_d  = clear_color_q;
        front_sel_d    = front_sel_q;
        swap_pending_d = swap_pending_q;
        swap_ack_d     = 1'b0;

        if (swap_now_s) begin
            front_sel_d    = ~front_sel_q;
            swap_pending_d = 1'b0;
            swap_ack_d     = 1'b1;
        end else if (swap_req) begin
            swap_pending_d = 1'b1;
        end else begin
            swap_pending_d = swap_pending_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d       = ST_CLEAR;
                    cnt_d         = {ADDR_W{1'b0}};
                    clear_color_d = clear_color;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = {ADDR_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + {{(ADDR_W - 1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Control registers with synchronous reset; memory contents are left untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= {ADDR_W{1'b0}};
            clear_color_q  <= {COLOR_W{1'b0}};
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_ack_q     <= 1'b0;
            vblank_q       <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_sel_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            clear_color_q  <= clear_color_d;
            front_sel_q    <= front_sel_d;
            swap_pending_q <= swap_pending_d;
            swap_ack_q     <= swap_ack_d;
            vblank_q       <= vblank;
            rd_valid_q     <= rd_ok_s;
            rd_sel_q       <= front_sel_q;
        end
    end

    // Back-bank write port: the clear engine owns it while filling, otherwise the renderer.
    always_comb begin
        wr_en_s = 1'b0;
        waddr_s = {ADDR_W{1'b0}};
        wdata_s = {COLOR_W{1'b0}};
        if (state_q == ST_CLEAR) begin
            wr_en_s = 1'b1;
            waddr_s = cnt_q;
            wdata_s = clear_color_q;
        end else if (we && in_range(wx, wy)) begin
            wr_en_s = 1'b1;
            waddr_s = pix_addr(wx, wy);
            wdata_s = wdata;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Route the write to the bank that is not being scanned out.
    always_comb begin
        bank_we_s    = 2'b00;
        bank_we_s[0] = wr_en_s & front_sel_q;
        bank_we_s[1] = wr_en_s & ~front_sel_q;
    end

    // Read address; out-of-range coordinates read address 0 and are masked at the output.
    always_comb begin
        rd_ok_s = in_range(rx, ry);
        if (rd_ok_s) begin
            raddr_s = pix_addr(rx, ry);
        end else begin
            raddr_s = {ADDR_W{1'b0}};
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fb_bank #(
            .DEPTH (PIX),
            .AW    (ADDR_W),
            .DW    (COLOR_W)
        ) u_bank (
            .clk     (clk),
            .we_i    (bank_we_s[b]),
            .waddr_i (waddr_s),
            .wdata_i (wdata_s),
            .raddr_i (raddr_s),
            .rdata_o (bank_rdata_s[b])
        );
    end

    // Output mux selected by the bank that was front when the read was issued.
    always_comb begin
        if (!rd_valid_q) begin
            rdata = {COLOR_W{1'b0}};
        end else if (rd_sel_q) begin
            rdata = bank_rdata_s[1];
        end else begin
            rdata = bank_rdata_s[0];
        end
    end

    assign clear_busy   = (state_q == ST_CLEAR);
    assign swap_pending = swap_pending_q;
    assign swap_ack     = swap_ack_q;
    assign front_sel    = front_sel_q;

endmodule
